scaler_h_ctrl: RTL
==================

Name: scaler_h_ctrl

Overview:
- Frame-synchronous configuration and supervision controller for the horizontal linear scaler (scaler_h).
- Accepts scale step and frame geometry from a register interface through a valid/ready handshake.
- Applies new settings only at a frame start, so the scaler never changes ratio mid-frame.
- Checks input line length and line count against the configured geometry, and measures the scaler's output width and height per frame.

Parameters:
- PIXEL_STEP, 128, fixed-point unity step (scale 1.0); scale_step = SCALE_COE*PIXEL_STEP.
- STEP_WIDTH, 16, width of scale_step.
- DIM_WIDTH, 16, width of all pixel and line counters and geometry fields.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cfg_step  in  STEP_WIDTH  requested scale step
- cfg_width  in  DIM_WIDTH  expected input pixels per line
- cfg_height  in  DIM_WIDTH  expected input lines per frame
- cfg_valid  in  1  config offer
- cfg_ready  out  1  controller can accept config
- cfg_applied  out  1  one-cycle pulse: pending config became active
- scale_step_o  out  STEP_WIDTH  active step, driven to scaler_h.scale_step
- de_i  in  1  scaler input data enable
- hs_i  in  1  scaler input line-start strobe (1 cycle)
- vs_i  in  1  scaler input frame-start strobe (1 cycle, coincident with first hs_i)
- de_o  in  1  scaler output data enable
- hs_o  in  1  scaler output line-start strobe
- vs_o  in  1  scaler output frame-start strobe
- busy_o  out  1  frame in progress
- out_width_o  out  DIM_WIDTH  de_o count of last completed output line
- out_height_o  out  DIM_WIDTH  output line count of last completed output frame
- err_len_o  out  1  sticky: input line length != cfg width
- err_frame_o  out  1  sticky: line count mismatch or early vs_i
- err_clr  in  1  clears both sticky errors

Behaviour:
- Reset values: scale_step_o = PIXEL_STEP, cfg_ready = 1, cfg_applied = 0, busy_o = 0, out_width_o = 0, out_height_o = 0, both errors = 0, state IDLE, pending flag = 0, active width/height = 0.
- Handshake:
  - Accept when cfg_valid & cfg_ready: latch pending regs, set pending; cfg_ready = !pending (registered, deasserts the cycle after accept).
  - cfg_step == 0 is accepted but discarded; the pending flag is not set.
  - Accepted step is clamped to the range [PIXEL_STEP/2, 16*PIXEL_STEP].
- Apply:
  - On vs_i with pending set: active regs <= pending, pending <= 0, cfg_applied pulses.
  - scale_step_o updates in the cycle after vs_i, which is before the first de_i the scaler consumes (the scaler input is registered once).
  - cfg_valid accepted on the same cycle as vs_i loads pending for the next frame only.
- FSM (input side):
  - IDLE: vs_i -> ACTIVE; line_cnt = 1, pix_cnt = 0.
  - ACTIVE: de_i increments pix_cnt.
    - hs_i: compare pix_cnt with active width; mismatch sets err_len. Then pix_cnt = 0, line_cnt += 1.
    - When line_cnt == height and pix_cnt reaches width: length check done -> DONE.
    - vs_i while ACTIVE: set err_frame, treat as a new frame start (apply pending, restart counters, stay ACTIVE).
  - DONE: vs_i -> ACTIVE, with the same actions as from IDLE. hs_i or de_i in DONE sets err_frame.
  - busy_o = (state == ACTIVE).
- Output measurement (independent of FSM):
  - Output pixel counter increments on de_o. On hs_o: out_width_o <= counter (skipped on the hs_o coincident with vs_o of the first frame after reset), counter <= 0 (or 1 if de_o is also high).
  - Line counter on hs_o. On vs_o: out_height_o <= line counter, line counter <= 1.
- Simultaneous events:
  - err_clr together with a new error -> error wins (remains 1).
  - de_i together with hs_i counts toward the new line.
- Counters saturate at all-ones; no wrap.
- Reset mid-frame returns everything to reset values immediately (async). The first vs_i after reset starts the frame cleanly.

Test Plan:
- PIXEL_STEP=128: offer cfg_step=179, width=16, height=4 while idle -> cfg_ready drops 1 cycle after accept; on the next vs_i, cfg_applied pulses and scale_step_o=179 one cycle later; cfg_ready returns to 1.
- Offer cfg_step=20 then cfg_step=4000 -> scale_step_o=64, then scale_step_o=2048 on successive frames; cfg_step=0 -> scale_step_o unchanged and cfg_applied stays 0.
- Frame of 4 lines x 16 pixels with the third line at 15 pixels -> err_len_o=1 after the fourth hs_i; err_frame_o=0; err_clr -> err_len_o=0.
- vs_i after only 2 of 4 lines -> err_frame_o=1; busy_o stays 1 and the new frame counts from line 1.
- Drive 8 de_o pulses per line, 3 hs_o lines, then vs_o -> out_width_o=8 after the 2nd hs_o; out_height_o=3 at vs_o.
- Assert rst during line 2 with pending config -> all outputs at reset values; next vs_i enters ACTIVE with scale_step_o=128.

Source files
------------

// File: rtl/scaler_h_ctrl.sv
// Frame-synchronous configuration and supervision controller for scaler_h:
// new scale settings take effect only at vs_i; input geometry is checked and output size measured.
module scaler_h_ctrl #(
  parameter int PIXEL_STEP = 128,
  parameter int STEP_WIDTH = 16,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STEP_WIDTH-1:0] cfg_step,
  input  logic [DIM_WIDTH-1:0]  cfg_width,
  input  logic [DIM_WIDTH-1:0]  cfg_height,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  cfg_applied,
  output logic [STEP_WIDTH-1:0] scale_step_o,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  input  logic                  de_o,
  input  logic                  hs_o,
  input  logic                  vs_o,
  output logic                  busy_o,
  output logic [DIM_WIDTH-1:0]  out_width_o,
  output logic [DIM_WIDTH-1:0]  out_height_o,
  output logic                  err_len_o,
  output logic                  err_frame_o,
  input  logic                  err_clr
);

  localparam logic [STEP_WIDTH-1:0] STEP_UNITY = STEP_WIDTH'(PIXEL_STEP);
  localparam logic [STEP_WIDTH-1:0] STEP_MIN   = STEP_WIDTH'(PIXEL_STEP / 2);
  localparam logic [STEP_WIDTH-1:0] STEP_MAX   = STEP_WIDTH'(16 * PIXEL_STEP);
  localparam logic [DIM_WIDTH-1:0]  DIM_ONE    = DIM_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE
  } state_t;

  function automatic logic [DIM_WIDTH-1:0] sat_inc(input logic [DIM_WIDTH-1:0] v);
    return (v == '1) ? v : v + DIM_ONE;
  endfunction

  // Configuration: pending (accepted) and active (in use this frame) copies
  logic                  r_pending;
  logic [STEP_WIDTH-1:0] r_pend_step;
  logic [DIM_WIDTH-1:0]  r_pend_width;
  logic [DIM_WIDTH-1:0]  r_pend_height;
  logic [STEP_WIDTH-1:0] r_scale_step;
  logic [DIM_WIDTH-1:0]  r_act_width;
  logic [DIM_WIDTH-1:0]  r_act_height;
  logic                  r_cfg_applied;

  logic                  w_accept;
  logic                  w_apply;
  logic [STEP_WIDTH-1:0] w_step_clamped;

  assign cfg_ready    = !r_pending;
  assign cfg_applied  = r_cfg_applied;
  assign scale_step_o = r_scale_step;
  assign w_accept     = cfg_valid && cfg_ready;
  assign w_apply      = vs_i && r_pending;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_step_clamped = cfg_step;
    if (cfg_step < STEP_MIN)      w_step_clamped = STEP_MIN;
    else if (cfg_step > STEP_MAX) w_step_clamped = STEP_MAX;
  end

  // NOTE: clocked state uses non-blocking (<=) so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending     <= 1'b0;
      r_pend_step   <= STEP_UNITY;
      r_pend_width  <= '0;
      r_pend_height <= '0;
      r_scale_step  <= STEP_UNITY;
      r_act_width   <= '0;
      r_act_height  <= '0;
      r_cfg_applied <= 1'b0;
    end else begin
      r_cfg_applied <= w_apply;
      if (w_apply) begin
        r_scale_step <= r_pend_step;
        r_act_width  <= r_pend_width;
        r_act_height <= r_pend_height;
      end
      // A zero step is consumed by the handshake but never becomes pending
      if (w_accept && (cfg_step != '0)) begin
        r_pend_step   <= w_step_clamped;
        r_pend_width  <= cfg_width;
        r_pend_height <= cfg_height;
        r_pending     <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Input-side frame supervision
  state_t               r_state;
  state_t               w_state_next;
  logic [DIM_WIDTH-1:0] r_pix_cnt;
  logic [DIM_WIDTH-1:0] r_line_cnt;
  logic [DIM_WIDTH-1:0] w_pix_next;
  logic [DIM_WIDTH-1:0] w_line_next;
  logic [DIM_WIDTH-1:0] w_frame_width;
  logic [DIM_WIDTH-1:0] w_frame_height;
  logic                 w_len_hit;
  logic                 w_frame_hit;
  logic                 r_err_len;
  logic                 r_err_frame;

  // Geometry that governs the frame starting now, including one being applied this cycle
  assign w_frame_width  = w_apply ? r_pend_width  : r_act_width;
  assign w_frame_height = w_apply ? r_pend_height : r_act_height;

  always_comb begin
    w_state_next = r_state;
    w_pix_next   = r_pix_cnt;
    w_line_next  = r_line_cnt;
    w_len_hit    = 1'b0;
    w_frame_hit  = 1'b0;
    if (vs_i) begin
      w_frame_hit  = (r_state == S_ACTIVE);
      w_state_next = S_ACTIVE;
      w_line_next  = DIM_ONE;
      w_pix_next   = DIM_WIDTH'(de_i);
    end else if (r_state == S_ACTIVE) begin
      if (hs_i) begin
        w_len_hit   = (r_pix_cnt != r_act_width);
        w_pix_next  = DIM_WIDTH'(de_i);
        w_line_next = sat_inc(r_line_cnt);
      end else if (de_i) begin
        w_pix_next = sat_inc(r_pix_cnt);
      end
    end else if (r_state == S_DONE) begin
      w_frame_hit = hs_i || de_i;
    end
    // Last pixel of the last line closes the frame
    if ((w_state_next == S_ACTIVE) && de_i &&
        (w_line_next == w_frame_height) && (w_pix_next == w_frame_width)) begin
      w_state_next = S_DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pix_cnt  <= w_pix_next;
      r_line_cnt <= w_line_next;
    end
  end

  // A new error in the same cycle as err_clr wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_len   <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      if (w_len_hit)    r_err_len <= 1'b1;
      else if (err_clr) r_err_len <= 1'b0;
      if (w_frame_hit)  r_err_frame <= 1'b1;
      else if (err_clr) r_err_frame <= 1'b0;
    end
  end

  assign busy_o      = (r_state == S_ACTIVE);
  assign err_len_o   = r_err_len;
  assign err_frame_o = r_err_frame;

  // Output-side measurement, independent of the input FSM
  logic [DIM_WIDTH-1:0] r_opix_cnt;
  logic [DIM_WIDTH-1:0] r_oline_cnt;
  logic [DIM_WIDTH-1:0] r_out_width;
  logic [DIM_WIDTH-1:0] r_out_height;
  logic                 r_seen_vs_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opix_cnt   <= '0;
      r_oline_cnt  <= '0;
      r_out_width  <= '0;
      r_out_height <= '0;
      r_seen_vs_o  <= 1'b0;
    end else begin
      if (vs_o) r_seen_vs_o <= 1'b1;
      if (hs_o) begin
        // The first line start after reset has no completed line behind it
        if (!(vs_o && !r_seen_vs_o)) r_out_width <= r_opix_cnt;
        r_opix_cnt <= DIM_WIDTH'(de_o);
      end else if (de_o) begin
        r_opix_cnt <= sat_inc(r_opix_cnt);
      end
      if (vs_o) begin
        r_out_height <= r_oline_cnt;
        r_oline_cnt  <= DIM_ONE;
      end else if (hs_o) begin
        r_oline_cnt <= sat_inc(r_oline_cnt);
      end
    end
  end

  assign out_width_o  = r_out_width;
  assign out_height_o = r_out_height;

endmodule
